// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the master bridge state type.
package apb_pkg;

   localparam int unsigned APB_AW = 32;
   localparam int unsigned APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_mst_state_e;

   // A zero timeout still needs a 1-bit counter so the declaration stays legal.
   function automatic int unsigned apb_cnt_width(int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into single APB4 transfers and returns one
// response per command (read data, slave error or wait-state timeout).
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned AW      = APB_AW,
   parameter int unsigned DW      = APB_DW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_strb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            rsp_timeout,
   output logic            PSEL,
   output logic            PENABLE,
   output logic            PWRITE,
   output logic [AW-1:0]   PADDR,
   output logic [DW-1:0]   PWDATA,
   output logic [DW/8-1:0] PSTRB,
   input  logic            PREADY,
   input  logic            PSLVERR,
   input  logic [DW-1:0]   PRDATA
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned CW = apb_cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CntLast = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   apb_mst_state_e  state_q;
   logic            psel_q;
   logic            penable_q;
   logic            pwrite_q;
   logic [AW-1:0]   paddr_q;
   logic [DW-1:0]   pwdata_q;
   logic [SW-1:0]   pstrb_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic            rsp_err_q;
   logic            rsp_timeout_q;
   logic [CW-1:0]   wait_cnt_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  state_q   <= SETUP;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  pwrite_q  <= cmd_write;
                  paddr_q   <= cmd_addr;
                  // Reads never expose write data or lanes on the bus.
                  pwdata_q  <= cmd_write ? cmd_wdata : '0;
                  pstrb_q   <= cmd_write ? cmd_strb : '0;
               end
            end

            SETUP: begin
               state_q    <= ACCESS;
               penable_q  <= 1'b1;
               wait_cnt_q <= '0;
            end

            ACCESS: begin
               if (PREADY) begin
                  state_q       <= RESP;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  pstrb_q       <= '0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= PSLVERR;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                  wait_cnt_q    <= '0;
               end else if ((TIMEOUT != 0) && (wait_cnt_q == CntLast)) begin
                  // This is the TIMEOUT-th consecutive stalled ACCESS cycle.
                  state_q       <= RESP;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  pstrb_q       <= '0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_rdata_q   <= '0;
                  wait_cnt_q    <= '0;
               end else if (TIMEOUT != 0) begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  wait_cnt_q  <= '0;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised scoreboard bench for apb_master_bridge with an in-bench APB slave model.
module tb_apb_master_bridge;

   localparam int TO = 16;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      bit          err;
      logic [31:0] rdata;
      int          bp;
      int          acc_cyc;
   } txn_t;

   logic        PCLK, PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   // Second instance with the timeout disabled.
   logic        n_cmd_valid, n_cmd_ready, n_rsp_valid, n_rsp_err, n_rsp_timeout;
   logic [31:0] n_rsp_rdata, n_paddr, n_pwdata;
   logic        n_psel, n_penable, n_pwrite, n_pready;
   logic [31:0] n_prdata;
   logic [3:0]  n_pstrb;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   txn_t plan[$];
   txn_t exp_q[$];

   apb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(TO)) u_dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .PRDATA(PRDATA)
   );

   apb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(0)) u_dut_nt (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready), .cmd_write(1'b0),
      .cmd_addr(32'h0000_0040), .cmd_wdata(32'hFFFF_FFFF), .cmd_strb(4'hF),
      .rsp_valid(n_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(n_rsp_rdata),
      .rsp_err(n_rsp_err), .rsp_timeout(n_rsp_timeout),
      .PSEL(n_psel), .PENABLE(n_penable), .PWRITE(n_pwrite), .PADDR(n_paddr),
      .PWDATA(n_pwdata), .PSTRB(n_pstrb), .PREADY(n_pready), .PSLVERR(1'b1),
      .PRDATA(n_prdata)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: number of ACCESS cycles and the response each command must produce.
   function automatic int model_acc(txn_t t);
      return (t.waits >= TO) ? TO : t.waits + 1;
   endfunction

   function automatic logic [33:0] model_rsp(txn_t t);
      bit to;
      to = (t.waits >= TO);
      if (to) return {1'b1, 1'b1, 32'h0};
      return {t.err, 1'b0, t.write ? 32'h0 : t.rdata};
   endfunction

   function automatic txn_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                               int waits, bit e, logic [31:0] r, int bp);
      txn_t t;
      t.write = w; t.addr = a; t.wdata = d; t.strb = s; t.waits = waits;
      t.err = e; t.rdata = r; t.bp = bp; t.acc_cyc = 0;
      return t;
   endfunction

   task automatic send(input txn_t t);
      bit ok;
      ok = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
      cmd_wdata = t.wdata; cmd_strb = t.strb;
      for (int i = 0; i < 300; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge PCLK);
      end
      if (!ok) begin
         chk("cmd_accept", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         t.acc_cyc = cyc + 1;
         plan.push_back(t);
         exp_q.push_back(t);
         @(posedge PCLK);
         #1;
         cmd_valid = 1'b0;
         cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
         cmd_write = 1'($urandom);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge PCLK);
      chk("drain", exp_q.size(), 0);
   endtask

   // APB slave model: fixes PREADY/PSLVERR/PRDATA from the plan and checks bus protocol.
   txn_t cur;
   bit   in_xfer = 1'b0;
   int   acc = 0;
   always @(negedge PCLK) begin
      if (!PRESETn) begin
         in_xfer = 1'b0;
         PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end else if (PSEL && !PENABLE) begin
         if (plan.size() == 0) begin
            chk("unexpected_setup", 1, 0);
         end else begin
            cur = plan.pop_front();
            in_xfer = 1'b1;
            acc = 0;
            chk("setup_cycle", cyc, cur.acc_cyc);
            chk("setup_bus", {PWRITE, PADDR, PWDATA, PSTRB},
                {cur.write, cur.addr, cur.write ? cur.wdata : 32'h0,
                 cur.write ? cur.strb : 4'h0});
         end
         PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end else if (PSEL && PENABLE && in_xfer) begin
         acc++;
         chk("access_bus", {PWRITE, PADDR, PWDATA, PSTRB},
             {cur.write, cur.addr, cur.write ? cur.wdata : 32'h0,
              cur.write ? cur.strb : 4'h0});
         PREADY = (acc == cur.waits + 1);
         // While stalled, present the opposite error/data so ignored values are visible.
         PSLVERR = PREADY ? cur.err : ~cur.err;
         PRDATA = PREADY ? cur.rdata : ~cur.rdata;
      end else begin
         if (in_xfer) begin
            chk("access_cycles", acc, model_acc(cur));
            in_xfer = 1'b0;
         end
         chk("idle_bus", {PENABLE, PSTRB}, 0);
         PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
   end

   // Response monitor: pops the scoreboard on each new response and applies backpressure.
   txn_t            e;
   bit              in_rsp = 1'b0;
   bit              hs_prev = 1'b0;
   int              bp = 0;
   logic [33:0]     held;
   always @(negedge PCLK) begin
      if (!PRESETn) begin
         in_rsp = 1'b0; hs_prev = 1'b0; rsp_ready = 1'b0;
      end else begin
         if (hs_prev) chk("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
         hs_prev = 1'b0;
         if (rsp_valid) begin
            if (!in_rsp) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 1, 0);
                  bp = 0;
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_fields", {rsp_err, rsp_timeout, rsp_rdata}, model_rsp(e));
                  chk("rsp_latency", cyc - e.acc_cyc, model_acc(e) + 1);
                  bp = e.bp;
               end
               in_rsp = 1'b1;
               held = {rsp_err, rsp_timeout, rsp_rdata};
            end else begin
               chk("rsp_stable", {rsp_err, rsp_timeout, rsp_rdata}, held);
            end
            chk("busy_during_rsp", {cmd_ready, PSEL, PENABLE}, 0);
            rsp_ready = (bp == 0);
            if (bp > 0) bp--;
            if (rsp_ready) begin
               hs_prev = 1'b1;
               in_rsp = 1'b0;
            end
         end else begin
            rsp_ready = 1'($urandom);
         end
      end
   end

   initial begin
      txn_t t;
      bit   ok;
      PRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      n_cmd_valid = 1'b0; n_pready = 1'b0; n_prdata = '0;
      #3;
      chk("reset_outputs",
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err,
           rsp_timeout}, 0);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("reset_release", {cmd_ready, rsp_valid}, 2'b10);

      send(mk(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'h0, 0));
      send(mk(1'b0, 32'h24, 32'h1111_2222, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0));
      send(mk(1'b1, 32'h38, 32'h0BAD_F00D, 4'b0011, 2, 1'b1, 32'h0, 0));
      send(mk(1'b0, 32'h4C, 32'h0, 4'h0, 40, 1'b0, 32'hCAFE_0001, 0));
      send(mk(1'b0, 32'h50, 32'h0, 4'h0, 15, 1'b0, 32'h1357_9BDF, 0));
      send(mk(1'b1, 32'h60, 32'h7777_8888, 4'b1100, 1, 1'b0, 32'h0, 5));
      send(mk(1'b0, 32'h64, 32'h0, 4'hF, 0, 1'b0, 32'h2468_ACE0, 0));

      for (int i = 0; i < 80; i++) begin
         t.write = 1'($urandom);
         t.addr = $urandom; t.wdata = $urandom; t.strb = 4'($urandom);
         t.waits = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(14, 20);
         t.err = ($urandom_range(0, 3) == 0);
         t.rdata = $urandom;
         t.bp = $urandom_range(0, 3);
         t.acc_cyc = 0;
         send(t);
      end
      drain();

      // Asynchronous reset while the slave is stalling an ACCESS.
      send(mk(1'b0, 32'h80, 32'h0, 4'h0, 12, 1'b0, 32'h5555_AAAA, 0));
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (PSEL && PENABLE) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reached_access", ok, 1);
      @(negedge PCLK);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("reset_mid_access",
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err,
           rsp_timeout}, 0);
      exp_q.delete();
      plan.delete();
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         chk("after_reset_idle", {cmd_ready, rsp_valid}, 2'b10);
      end
      send(mk(1'b0, 32'h84, 32'h0, 4'h0, 1, 1'b0, 32'h0F0F_F0F0, 0));
      drain();
      chk("plan_empty", plan.size(), 0);

      // Timeout disabled: the transfer must wait as long as the slave stalls.
      @(negedge PCLK);
      n_cmd_valid = 1'b1;
      chk("nt_cmd_ready", n_cmd_ready, 1);
      @(posedge PCLK);
      #1;
      n_cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("nt_setup", {n_psel, n_penable, n_pstrb}, {2'b10, 4'h0});
      @(negedge PCLK);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!(n_psel && n_penable && !n_rsp_valid)) ok = 1'b0;
         @(negedge PCLK);
      end
      chk("nt_no_timeout", ok, 1);
      n_pready = 1'b1;
      n_prdata = 32'h1234_5678;
      @(negedge PCLK);
      n_pready = 1'b0;
      chk("nt_rsp", {n_rsp_valid, n_rsp_err, n_rsp_timeout, n_rsp_rdata},
          {3'b110, 32'h1234_5678});
      @(negedge PCLK);
      chk("nt_done", {n_cmd_ready, n_rsp_valid, n_psel}, 3'b100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
